// File: rtl/feature_map_scan_counter.sv
// feature_map_scan_counter: col/row/chan index sequencer for one feature-map tile under start/ready handshake
module feature_map_scan_counter #(
    parameter int CW  = 11,
    parameter int RW  = 11,
    parameter int CHW = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic [CW-1:0]  cfg_cols,
    input  logic [RW-1:0]  cfg_rows,
    input  logic [CHW-1:0] cfg_chans,
    input  logic           ready,
    output logic           valid,
    output logic [CW-1:0]  col,
    output logic [RW-1:0]  row,
    output logic [CHW-1:0] chan,
    output logic           last_col,
    output logic           last_row,
    output logic           busy,
    output logic           done,
    output logic           cfg_err
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0]     state;
    logic [CW-1:0]  cols;
    logic [RW-1:0]  rows;
    logic [CHW-1:0] chans;
    logic           last_chan, cfg_ok;
    assign valid     = state == RUN;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    // latched counts are nonzero whenever valid, so minus-one never wraps
    assign last_col  = valid && col == cols - CW'(1);
    assign last_row  = last_col && row == rows - RW'(1);
    assign last_chan = chan == chans - CHW'(1);
    assign cfg_ok    = |cfg_cols && |cfg_rows && |cfg_chans;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            col     <= '0;
            row     <= '0;
            chan    <= '0;
            cols    <= '0;
            rows    <= '0;
            chans   <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (abort) begin
                state <= IDLE;
                col   <= '0;
                row   <= '0;
                chan  <= '0;
            end else if (state == IDLE) begin
                if (start && cfg_ok) begin
                    cols  <= cfg_cols;
                    rows  <= cfg_rows;
                    chans <= cfg_chans;
                    col   <= '0;
                    row   <= '0;
                    chan  <= '0;
                    state <= RUN;
                end else if (start) begin
                    cfg_err <= 1'b1;
                end
            end else if (state == RUN) begin
                if (ready) begin
                    col <= last_col ? '0 : col + CW'(1);
                    if (last_col)
                        row <= last_row ? '0 : row + RW'(1);
                    if (last_row) begin
                        chan  <= last_chan ? '0 : chan + CHW'(1);
                        state <= last_chan ? DONE : RUN;
                    end
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: doc/feature_map_scan_counter.md
Name: feature_map_scan_counter

Overview:
- Parametrised successor to the fixed 640-pixel line counter.
- Generates a column/row/channel index sequence for one feature-map tile (col innermost, then row, then channel) under a start/ready handshake.
- Frame size is configurable at run time; signals line, frame and tile completion.
- Sits between the layer controller (start, cfg) and the line-buffer/PE address generators (valid, indices, ready).

Parameters:
- CW, 11, width of column index and cfg_cols (supports 640 and 1280-wide frames)
- RW, 11, width of row index and cfg_rows
- CHW, 8, width of channel index and cfg_chans

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request a new scan; sampled only in IDLE
- abort  in  1  synchronous; returns to IDLE from any state, no done
- cfg_cols  in  CW  column count (1..2^CW-1); latched on accepted start
- cfg_rows  in  RW  row count; latched on accepted start
- cfg_chans  in  CHW  channel count; latched on accepted start
- ready  in  1  downstream accepts the current index this cycle
- valid  out  1  col/row/chan hold a valid index
- col  out  CW  current column
- row  out  RW  current row
- chan  out  CHW  current channel
- last_col  out  1  valid && col == cols-1
- last_row  out  1  last_col && row == rows-1 (end of one channel plane)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the final index is accepted
- cfg_err  out  1  one-cycle pulse: start rejected because a cfg field is zero

Behaviour:
- Reset values: state IDLE; valid, busy, done, cfg_err, last_col, last_row = 0; col, row, chan = 0; latched cfg = 0.
- States: IDLE, RUN, DONE.
- IDLE, start=1, all cfg fields nonzero:
  - latch cfg; col/row/chan <= 0; go to RUN.
  - valid=1 from the next cycle (1-cycle start latency).
- IDLE, start=1, any cfg field zero: cfg_err=1 for one cycle; stay in IDLE; cfg not latched.
- RUN, ready=0: all indices hold; valid stays 1.
- RUN, ready=1, advance in this order:
  - if col != cols-1: col <= col+1.
  - else: col <= 0; if row != rows-1: row <= row+1.
  - else: row <= 0; if chan != chans-1: chan <= chan+1.
  - else (final index): go to DONE; indices <= 0.
- DONE: valid=0, done=1 for exactly one cycle, then IDLE.
  - busy stays 1 in DONE and drops in the next IDLE cycle.
  - start is ignored in DONE; a new start is accepted the cycle after DONE.
- start in RUN or DONE is ignored. cfg inputs are ignored except on an accepted start.
- abort=1 in any state:
  - next state IDLE; valid=0; indices <= 0.
  - no done pulse; abort has priority over ready and start.
- Comparisons are against the latched cfg minus 1, computed at full width. cols = 2^CW-1 must work without overflow.
- last_col and last_row are combinational from the registered indices; both are 0 whenever valid=0.
- Simultaneous ready and final index: done follows on the next cycle; no extra valid beat is issued.
- Total accepted beats per scan = cols*rows*chans exactly.
- Asynchronous reset mid-RUN: outputs go to reset values immediately; no done.

Test Plan:
- cfg 4x3x2, start, ready=1: 24 beats, index order (0,0,0)..(3,2,1); last_col on every 4th beat; last_row on beats 12 and 24; done pulses in the cycle after beat 24; busy drops one cycle later.
- Same cfg, ready toggling with random 50% duty: indices hold while ready=0; still exactly 24 accepted beats; same order; a single done pulse.
- cfg 640x640x1 (the legacy row case), ready=1: col wraps 639->0 with row increment; done after 409600 beats; col never reaches 640.
- cfg 1x1x1: one valid beat with last_col=last_row=1; done the next cycle. cfg_cols=0: cfg_err pulse, busy stays 0, no valid.
- start pulsed mid-RUN with new cfg: ignored, scan finishes with the original cfg. abort at beat 7 of the 4x3x2 scan: valid=0 next cycle, no done; a fresh start then scans from (0,0,0).
- Assert reset asynchronously mid-RUN, off a clock edge: valid/busy/indices go to 0 without waiting for a clock edge; no done pulse after release.
